// File: rtl/bw_pixel_streamer.sv
// ---------------------------------------------------------------------------
// bw_pixel_streamer
//
// Front-end transmitter for the serial black-and-white line buffer.
// Grayscale pixels arrive in raster order over a valid/ready handshake. Each
// accepted pixel is thresholded to a single bit. One cycle later that bit is
// presented on d_out, with the line buffer's active-low shift enable (ena)
// pulled low for exactly that cycle. Column and row counters follow the
// emitted bit. A pulse marks frame completion, and another marks a
// start-of-frame that arrives in the middle of a frame.
//
// Parameters
//   IMG_W   pixels per line (>= 2)
//   IMG_H   lines per frame (>= 2)
//   PIX_W   grayscale pixel width
//   THRESH  threshold: bit = (pix >= threshold), unsigned compare
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   pix_in      grayscale pixel
//   pix_valid   pix_in valid
//   pix_sof     marks pix_in as pixel (0,0), sampled with pix_valid
//   pix_ready   pixel accepted this cycle when pix_valid is also high
//   hold        downstream stall, blocks acceptance while streaming
//   d_out       thresholded bit to the line buffer d_in
//   ena         line buffer shift enable, active-low
//   col, row    position of the last emitted bit
//   frame_done  1-cycle pulse after the last pixel of a frame is emitted
//   resync_err  1-cycle pulse, in the emit cycle, when SOF arrives mid-frame
//
// Optional feature (macro THRESH_PROG_EN)
//   When THRESH_PROG_EN is defined, two ports are added: thr_in and thr_load.
//   thr_load=1 registers thr_in as the new threshold. The reset value is
//   THRESH. The new value applies only to pixels accepted after the load
//   cycle. When the macro is undefined, the threshold is the constant THRESH.
// ---------------------------------------------------------------------------
module bw_pixel_streamer #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int PIX_W  = 8,
    parameter int THRESH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     pix_sof,
    output logic                     pix_ready,
    input  logic                     hold,
`ifdef THRESH_PROG_EN
    input  logic [PIX_W-1:0]         thr_in,
    input  logic                     thr_load,
`endif
    output logic                     d_out,
    output logic                     ena,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic                     frame_done,
    output logic                     resync_err
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t state;

    logic [PIX_W-1:0] thr;
    logic             accept;
    logic             emit;
    logic             pix_bit;
    logic [COL_W-1:0] next_col;
    logic [ROW_W-1:0] next_row;
    logic             next_is_last;

    // Threshold source. The programmable register updates at the clock edge.
    // A pixel accepted in the same cycle as a load is therefore still compared
    // against the old value.
`ifdef THRESH_PROG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr <= PIX_W'(THRESH);
        end else if (thr_load) begin
            thr <= thr_in;
        end
    end
`else
    assign thr = PIX_W'(THRESH);
`endif

    // Ready is combinational, so that hold stalls acceptance in the same
    // cycle. In IDLE the block always accepts, so that stray non-SOF pixels
    // are drained. Ready is forced low while reset is asserted.
    always_comb begin
        pix_ready = 1'b0;
        if (rst) begin
            case (state)
                IDLE:    pix_ready = 1'b1;
                STREAM:  pix_ready = !hold;
                default: pix_ready = 1'b0;
            endcase
        end
    end

    assign accept  = pix_valid & pix_ready;
    assign pix_bit = (pix_in >= thr);

    // A pixel is emitted only when it belongs to a frame. That is either any
    // pixel in STREAM, or an SOF pixel that opens a frame from IDLE. A non-SOF
    // pixel accepted in IDLE is dropped silently.
    assign emit = accept & ((state == STREAM) | pix_sof);

    // Position the accepted pixel will take. SOF (or leaving IDLE) restarts
    // at (0,0). Otherwise the column advances and wraps into the next row.
    always_comb begin
        next_col = '0;
        next_row = '0;
        if (!pix_sof && state == STREAM) begin
            if (col == COL_LAST) begin
                next_col = '0;
                next_row = row + 1'b1;
            end else begin
                next_col = col + 1'b1;
                next_row = row;
            end
        end
    end

    assign next_is_last = (next_col == COL_LAST) && (next_row == ROW_LAST);

    // Main sequencer. All outputs are registered, so an accepted pixel shows
    // up one cycle later with ena low. frame_done and resync_err default low
    // each cycle, which makes them single-cycle pulses. An asynchronous reset
    // drops any pixel accepted in the cycle before, because ena is forced high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            d_out      <= 1'b0;
            ena        <= 1'b1;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            ena        <= !emit;
            frame_done <= 1'b0;
            resync_err <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (emit) begin
                        d_out      <= pix_bit;
                        col        <= next_col;
                        row        <= next_row;
                        resync_err <= (state == STREAM) && pix_sof;
                        state      <= next_is_last ? DONE : STREAM;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bw_pixel_streamer.sv
// ---------------------------------------------------------------------------
// tb_bw_pixel_streamer
//
// Scoreboard bench for bw_pixel_streamer on a small 4x2 image.
//
// The driver works one cycle at a time. Each cycle it predicts pix_ready from
// a frame-level model: whether a frame is open, the pixel index in the frame,
// and the one blocked cycle after a frame ends. For every pixel that should
// be emitted, it pushes the expected bit, position, resync flag and emit
// cycle into a queue.
//
// The monitor samples on the falling edge. It checks ena against the head of
// the queue, then pops and compares every emitted bit. It also checks the
// frame_done pulse timing.
//
// Building with THRESH_PROG_EN enables the programmable-threshold stimulus.
// ---------------------------------------------------------------------------
module tb_bw_pixel_streamer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int PW = 8;
    localparam int TH = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          pix_ready;
    logic          hold = 1'b0;
    logic          d_out;
    logic          ena;
    logic [1:0]    col;
    logic          row;
    logic          frame_done;
    logic          resync_err;
`ifdef THRESH_PROG_EN
    logic [PW-1:0] thr_in = '0;
    logic          thr_load = 1'b0;
`endif

    bw_pixel_streamer #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (PW),
        .THRESH(TH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .hold      (hold),
`ifdef THRESH_PROG_EN
        .thr_in    (thr_in),
        .thr_load  (thr_load),
`endif
        .d_out     (d_out),
        .ena       (ena),
        .col       (col),
        .row       (row),
        .frame_done(frame_done),
        .resync_err(resync_err)
    );

    // 10-unit clock; the bench counts rising edges to time-stamp emissions.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit d;
        int col;
        int row;
        bit resync;
        bit last;
        int emit_cyc;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level reference model state.
    int            m_pos = 0;
    bit            m_in_frame = 1'b0;
    bit            m_blocked = 1'b0;
    logic [PW-1:0] m_thr = PW'(TH);
    bit            in_reset = 1'b1;
    int            fd_cyc = -1;
    bit            thr_load_n = 1'b0;
    logic [PW-1:0] thr_in_n = '0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One cycle of stimulus. It drives the inputs just after the rising edge,
    // checks pix_ready against the model, and pushes the expected emission
    // when the model says the pixel belongs to a frame.
    task automatic applyStimulus(input bit v, input bit s, input logic [PW-1:0] p, input bit h);
        bit   rdy_exp;
        bit   acc;
        exp_t e;
        @(posedge clk);
        #1;
        pix_valid = v;
        pix_sof   = s;
        pix_in    = p;
        hold      = h;
`ifdef THRESH_PROG_EN
        thr_in    = thr_in_n;
        thr_load  = thr_load_n;
`endif
        #1;
        rdy_exp   = m_blocked ? 1'b0 : (!m_in_frame ? 1'b1 : !h);
        m_blocked = 1'b0;
        checkOutput("pix_ready", int'(pix_ready), int'(rdy_exp));
        acc = v && rdy_exp;
        if (acc && (s || m_in_frame)) begin
            e.resync = s && m_in_frame;
            if (s) m_pos = 0;
            else   m_pos++;
            m_in_frame = 1'b1;
            e.d        = (p >= m_thr);
            e.col      = m_pos % W;
            e.row      = m_pos / W;
            e.emit_cyc = cyc + 1;
            e.last     = (m_pos == W * H - 1);
            if (e.last) begin
                m_in_frame = 1'b0;
                m_blocked  = 1'b1;
            end
            sb.push_back(e);
        end
`ifdef THRESH_PROG_EN
        if (thr_load_n) m_thr = thr_in_n;
`endif
    endtask

    // Assert reset, check the cleared outputs, then release.
    // With now=1, reset lands in the same cycle as the preceding accept,
    // so that pixel is still in flight and must be dropped.
    task automatic applyReset(input bit now);
        if (!now) @(posedge clk);
        #1;
        in_reset  = 1'b1;
        rst       = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        hold      = 1'b0;
        thr_load_n = 1'b0;
`ifdef THRESH_PROG_EN
        thr_load  = 1'b0;
`endif
        #1;
        checkOutput("rst_d_out",      int'(d_out),      0);
        checkOutput("rst_ena",        int'(ena),        1);
        checkOutput("rst_col",        int'(col),        0);
        checkOutput("rst_row",        int'(row),        0);
        checkOutput("rst_pix_ready",  int'(pix_ready),  0);
        checkOutput("rst_frame_done", int'(frame_done), 0);
        checkOutput("rst_resync_err", int'(resync_err), 0);
        sb.delete();
        m_pos      = 0;
        m_in_frame = 1'b0;
        m_blocked  = 1'b0;
        m_thr      = PW'(TH);
        fd_cyc     = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        in_reset = 1'b0;
    endtask

    // Monitor: on each falling edge, ena must be low exactly when the queue
    // head is due. The due entry is then popped and compared.
    always @(negedge clk) begin : monitor
        bit   emit_now;
        exp_t e;
        if (!in_reset) begin
            while (sb.size() > 0 && sb[0].emit_cyc < cyc) begin
                e = sb.pop_front();
                n_cmp++;
                n_err++;
                $display("[TB] FAIL emit_missed: got no emission, expected bit at row %0d col %0d (cycle %0d)",
                         e.row, e.col, cyc);
            end
            emit_now = (sb.size() > 0) && (sb[0].emit_cyc == cyc);
            checkOutput("ena", int'(ena), emit_now ? 0 : 1);
            if (emit_now) begin
                e = sb.pop_front();
                checkOutput("d_out",      int'(d_out),      int'(e.d));
                checkOutput("col",        int'(col),        e.col);
                checkOutput("row",        int'(row),        e.row);
                checkOutput("resync_err", int'(resync_err), int'(e.resync));
                if (e.last) fd_cyc = cyc + 1;
            end else begin
                checkOutput("resync_err", int'(resync_err), 0);
            end
            checkOutput("frame_done", int'(frame_done), (cyc == fd_cyc) ? 1 : 0);
        end
    end

    function automatic logic [PW-1:0] randPix();
        logic [PW-1:0] p;
        if ($urandom_range(3) == 0) p = PW'(TH - 1 + int'($urandom_range(1)));
        else                        p = PW'($urandom);
        return p;
    endfunction

    initial begin
        // Power-on reset.
        #1 rst = 1'b0;
        #2;
        checkOutput("por_d_out",     int'(d_out),     0);
        checkOutput("por_ena",       int'(ena),       1);
        checkOutput("por_col",       int'(col),       0);
        checkOutput("por_row",       int'(row),       0);
        checkOutput("por_pix_ready", int'(pix_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #1 in_reset = 1'b0;

        // Threshold edge: SOF pixels 127, 128, 255, 0 back to back.
        applyStimulus(1, 1, 8'd127, 0);
        applyStimulus(1, 1, 8'd128, 0);
        applyStimulus(1, 1, 8'd255, 0);
        applyStimulus(1, 1, 8'd0,   0);
        repeat (2) applyStimulus(0, 0, 8'd0, 0);
        applyReset(0);

        // Non-SOF pixel in IDLE is accepted (even under hold) and discarded.
        applyStimulus(1, 0, 8'd200, 1);

        // Full frame back to back: line wrap and frame_done.
        for (int i = 0; i < W * H; i++) applyStimulus(1, (i == 0), randPix(), 0);
        repeat (3) applyStimulus(0, 0, 8'd0, 0);

        // Stall: hold for three cycles after pixel 2.
        for (int i = 0; i < 2; i++) applyStimulus(1, (i == 0), randPix(), 0);
        repeat (3) applyStimulus(1, 0, randPix(), 1);
        for (int i = 2; i < W * H; i++) applyStimulus(1, 1'b0, randPix(), 0);
        repeat (3) applyStimulus(0, 0, 8'd0, 0);

        // Resync: SOF on pixel 5; the frame restarts and then completes.
        for (int i = 0; i < 5 + W * H; i++) applyStimulus(1, (i == 0 || i == 5), randPix(), 0);
        repeat (3) applyStimulus(0, 0, 8'd0, 0);

        // Mid-frame reset with a pixel in flight.
        applyStimulus(1, 1, 8'd255, 0);
        applyStimulus(1, 0, 8'd255, 0);
        applyStimulus(1, 0, 8'd255, 0);
        applyReset(1);
        repeat (2) applyStimulus(0, 0, 8'd0, 0);

`ifdef THRESH_PROG_EN
        // Programmable threshold: load 200, then 199 -> 0 and 200 -> 1.
        // After reset, 128 -> 1 again.
        thr_in_n   = 8'd200;
        thr_load_n = 1'b1;
        applyStimulus(0, 0, 8'd0, 0);
        thr_load_n = 1'b0;
        applyStimulus(1, 1, 8'd199, 0);
        applyStimulus(1, 0, 8'd200, 0);
        applyReset(0);
        applyStimulus(1, 1, 8'd128, 0);
        repeat (2) applyStimulus(0, 0, 8'd0, 0);
`endif

        // Randomized traffic with occasional SOF, stalls and resets.
        for (int i = 0; i < 800; i++) begin
`ifdef THRESH_PROG_EN
            thr_load_n = ($urandom_range(15) == 0);
            thr_in_n   = PW'($urandom);
`endif
            if ($urandom_range(199) == 0) begin
                applyReset(0);
            end else begin
                applyStimulus(($urandom_range(9) < 7), ($urandom_range(24) == 0),
                              randPix(), ($urandom_range(4) == 0));
            end
        end
        thr_load_n = 1'b0;
        repeat (4) applyStimulus(0, 0, 8'd0, 0);
        @(posedge clk);
        #1;
        checkOutput("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
